alu_issue_stage: RTL

Execute-stage front end that drives the combinational ALU in `Pipeline/3-Execute`. It accepts decoded RV32I OP/OP-IMM instructions from decode over a valid/ready handshake, translates `funct3`/`funct7[5]` into the ALU's 3-bit `aluOp`, and conditions the operands so the ALU's eight operations cover the full non-arithmetic-shift integer set. It captures the ALU result in a registered output stage toward writeback. Both stages are buffered, so throughput is one instruction per cycle with backpressure.

---
 rtl/alu_issue_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-stage front end for the combinational RV32I ALU.
// Decodes funct3/funct7b5 into the ALU's 3-bit op, conditions the operands
// (shift-amount masking, sign flip for signed compare), holds the
// instruction in an E register that drives the ALU, and captures the ALU
// result in a W register toward writeback. Both stages use valid/ready
// handshakes so a full pipeline sustains one instruction per cycle.
`timescale 1ns/1ps

module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            decValid,
    output logic            decReady,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            isImm,
    input  logic [XLEN-1:0] rs1Value,
    input  logic [XLEN-1:0] rs2Value,
    input  logic [XLEN-1:0] immValue,
    input  logic [4:0]      rd,
    output logic [XLEN-1:0] aluOperand1,
    output logic [XLEN-1:0] aluOperand2,
    output logic [2:0]      aluOp,
    input  logic [XLEN-1:0] aluResult,
    output logic            wbValid,
    input  logic            wbReady,
    output logic [XLEN-1:0] wbResult,
    output logic [4:0]      wbRd,
    output logic            wbIllegal
);

    // Encoding understood by the downstream ALU.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SLT = 3'b111
    } aluOpE;

    logic            eValid;
    aluOpE           eOp;
    logic [XLEN-1:0] eOperand1;
    logic [XLEN-1:0] eOperand2;
    logic [4:0]      eRd;
    logic            eIllegal;
    logic            wValid;

    aluOpE           dOp;
    logic [XLEN-1:0] dOperand1;
    logic [XLEN-1:0] dOperand2;
    logic            dIllegal;
    logic [XLEN-1:0] src2;
    logic            b5Counts;

    logic            wMove;
    logic            accept;
    logic            forward;

    // W can take a new result when empty or when its current one leaves;
    // E can take a new instruction when empty or when it can advance into W.
    assign wMove    = !wValid || wbReady;
    assign decReady = !eValid || wMove;
    assign accept   = decValid && decReady;
    assign forward  = eValid && wMove;

    assign aluOp       = eOp;
    assign aluOperand1 = eOperand1;
    assign aluOperand2 = eOperand2;
    assign wbValid     = wValid;

    // Decode funct3/funct7b5 into an ALU op and condition the operands so the
    // ALU's single unsigned compare and logical shifts cover the RV32I set.
    always_comb begin
        src2      = isImm ? immValue : rs2Value;
        b5Counts  = !isImm || (funct3 == 3'b001) || (funct3 == 3'b101);
        dIllegal  = b5Counts && funct7b5 && !((funct3 == 3'b000) && !isImm);
        dOperand1 = rs1Value;
        dOperand2 = src2;
        dOp       = OP_ADD;
        case (funct3)
            3'b000: dOp = (!isImm && funct7b5) ? OP_SUB : OP_ADD;
            3'b001: begin
                dOp       = OP_SLL;
                dOperand2 = {{(XLEN-5){1'b0}}, src2[4:0]};
            end
            3'b010: begin
                // Flipping the sign bits turns an unsigned compare into a signed one.
                dOp       = OP_SLT;
                dOperand1 = {~rs1Value[XLEN-1], rs1Value[XLEN-2:0]};
                dOperand2 = {~src2[XLEN-1], src2[XLEN-2:0]};
            end
            3'b011: dOp = OP_SLT;
            3'b100: dOp = OP_XOR;
            3'b101: begin
                dOp       = OP_SRL;
                dOperand2 = {{(XLEN-5){1'b0}}, src2[4:0]};
            end
            3'b110: dOp = OP_OR;
            3'b111: dOp = OP_AND;
            default: dOp = OP_ADD;
        endcase
    end

    // E register: loads accepted instructions, empties when forwarded to W,
    // and is killed by flush even if an instruction was accepted this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eValid    <= 1'b0;
            eOp       <= OP_ADD;
            eOperand1 <= '0;
            eOperand2 <= '0;
            eRd       <= '0;
            eIllegal  <= 1'b0;
        end else begin
            if (flush) begin
                eValid <= 1'b0;
            end else if (accept) begin
                eValid <= 1'b1;
            end else if (forward) begin
                eValid <= 1'b0;
            end
            if (accept && !flush) begin
                eOp       <= dOp;
                eOperand1 <= dOperand1;
                eOperand2 <= dOperand2;
                eRd       <= rd;
                eIllegal  <= dIllegal;
            end
        end
    end

    // W register: captures the ALU result (zeroed for illegal instructions)
    // and holds it until writeback takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wValid    <= 1'b0;
            wbResult  <= '0;
            wbRd      <= '0;
            wbIllegal <= 1'b0;
        end else begin
            if (flush) begin
                wValid <= 1'b0;
            end else if (forward) begin
                wValid <= 1'b1;
            end else if (wbReady) begin
                wValid <= 1'b0;
            end
            if (forward && !flush) begin
                wbResult  <= eIllegal ? '0 : aluResult;
                wbRd      <= eRd;
                wbIllegal <= eIllegal;
            end
        end
    end

endmodule
